// File: rtl/ro_puf_pkg.sv
// Shared types, default sizes and width helpers for the RO-PUF response generator.
package ro_puf_pkg;

  // Measurement sequencer states
  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    COUNT,
    DRAIN,
    COMPARE,
    DONE
  } state_t;

  // Default sizing of the response generator
  localparam int DEF_NUM_RO        = 16;
  localparam int DEF_SEL_W         = 4;
  localparam int DEF_CNT_W         = 16;
  localparam int DEF_WINDOW_CYCLES = 50000;
  localparam int DEF_SETTLE_CYCLES = 8;
  localparam int DEF_DRAIN_CYCLES  = 4;

  // Width of a down-counter loaded with (cycles-1) and run to zero
  function automatic int win_cnt_w(input int cycles);
    if (cycles <= 2) begin
      return 1;
    end
    return $clog2(cycles);
  endfunction

  // Largest of the three phase lengths; one phase counter serves them all
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end
    if (c > m) begin
      m = c;
    end
    return m;
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronizes one asynchronous RO output into clk, detects its rising
// edges and counts them in a saturating counter.
module ro_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             async_in,
  output logic [CNT_W-1:0] count
);

  logic sync1;
  logic sync2;
  logic sync2_d;
  logic rise;

  // Two-flop synchronizer plus one delay stage for the edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= async_in;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign rise = sync2 & ~sync2_d;

  // Saturating edge count; clear has priority, all-ones is sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && rise && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ro_puf_response_gen.sv
// Runs one PUF challenge: enables a pair of ring oscillators, counts their
// edges over a fixed window, and reports which one ran faster.
module ro_puf_response_gen
  import ro_puf_pkg::*;
#(
  parameter int NUM_RO        = DEF_NUM_RO,
  parameter int SEL_W         = DEF_SEL_W,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int DRAIN_CYCLES  = DEF_DRAIN_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SEL_W-1:0]  challenge_a,
  input  logic [SEL_W-1:0]  challenge_b,
  input  logic [NUM_RO-1:0] ro_out,
  output logic [NUM_RO-1:0] ro_enable,
  output logic              busy,
  output logic              done,
  output logic              response,
  output logic              tie,
  output logic [CNT_W-1:0]  count_a,
  output logic [CNT_W-1:0]  count_b
);

  localparam int PH_MAX = max3(SETTLE_CYCLES, WINDOW_CYCLES, DRAIN_CYCLES);
  localparam int PH_W   = win_cnt_w(PH_MAX);

  localparam logic [PH_W-1:0] SETTLE_LOAD = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0] WINDOW_LOAD = PH_W'(WINDOW_CYCLES - 1);
  localparam logic [PH_W-1:0] DRAIN_LOAD  = PH_W'(DRAIN_CYCLES - 1);

  state_t            state;
  logic [SEL_W-1:0]  sel_a;
  logic [SEL_W-1:0]  sel_b;
  logic [PH_W-1:0]   phase;

  logic [NUM_RO-1:0] en_decode;
  logic [NUM_RO-1:0] hit_a;
  logic [NUM_RO-1:0] hit_b;
  logic              mux_a;
  logic              mux_b;
  logic              start_ok;
  logic              cnt_clr;
  logic              cnt_en;
  logic [CNT_W-1:0]  live_a;
  logic [CNT_W-1:0]  live_b;

  // Per-RO decode: enable bits for the incoming challenge, and one-hot
  // select masks for the latched challenge. An index past NUM_RO matches
  // no bit, so that channel sees a constant 0 and its enable never exists.
  for (genvar gi = 0; gi < NUM_RO; gi++) begin : g_ro_sel
    assign en_decode[gi] = (challenge_a == SEL_W'(gi)) || (challenge_b == SEL_W'(gi));
    assign hit_a[gi]     = ro_out[gi] & (sel_a == SEL_W'(gi));
    assign hit_b[gi]     = ro_out[gi] & (sel_b == SEL_W'(gi));
  end

  assign mux_a = |hit_a;
  assign mux_b = |hit_b;

  // Counters are held clear from the accepted start through SETTLE, and run
  // through COUNT and DRAIN so edges still in the synchronizer are absorbed.
  assign start_ok = (state == IDLE) && start;
  assign cnt_clr  = start_ok || (state == SETTLE);
  assign cnt_en   = (state == COUNT) || (state == DRAIN);

  ro_edge_counter #(
    .CNT_W    (CNT_W)
  ) u_cnt_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .async_in (mux_a),
    .count    (live_a)
  );

  ro_edge_counter #(
    .CNT_W    (CNT_W)
  ) u_cnt_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .async_in (mux_b),
    .count    (live_b)
  );

  // Measurement sequencer with registered enables, status and results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel_a     <= '0;
      sel_b     <= '0;
      phase     <= '0;
      ro_enable <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      response  <= 1'b0;
      tie       <= 1'b0;
      count_a   <= '0;
      count_b   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sel_a     <= challenge_a;
            sel_b     <= challenge_b;
            ro_enable <= en_decode;
            busy      <= 1'b1;
            response  <= 1'b0;
            tie       <= 1'b0;
            count_a   <= '0;
            count_b   <= '0;
            phase     <= SETTLE_LOAD;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          if (phase == '0) begin
            phase <= WINDOW_LOAD;
            state <= COUNT;
          end else begin
            phase <= phase - PH_W'(1);
          end
        end
        COUNT: begin
          if (phase == '0) begin
            ro_enable <= '0;
            phase     <= DRAIN_LOAD;
            state     <= DRAIN;
          end else begin
            phase <= phase - PH_W'(1);
          end
        end
        DRAIN: begin
          if (phase == '0) begin
            state <= COMPARE;
          end else begin
            phase <= phase - PH_W'(1);
          end
        end
        COMPARE: begin
          // Results land together with the done pulse on the next cycle
          count_a  <= live_a;
          count_b  <= live_b;
          response <= (live_a > live_b);
          tie      <= (live_a == live_b);
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_response_gen.sv
// Self-checking bench for ro_puf_response_gen with modelled ring oscillators.
module tb_ro_puf_response_gen;

  localparam int N   = 12;
  localparam int SW  = 4;
  localparam int CW  = 8;
  localparam int W   = 1200;
  localparam int S   = 8;
  localparam int D   = 4;
  localparam int T   = 10;
  localparam int DL  = S + W + D + 1;       // cycles from acceptance edge to done
  localparam int LAT = 1 + S + W + D + 1;   // start cycle to done cycle
  localparam int SAT = 255;

  // Half periods of the modelled ROs in time units (clk period is 10)
  localparam int HALF [N] = '{30, 20, 40, 50, 30, 70, 40, 60, 20, 50, 30, 40};

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [SW-1:0] challenge_a = '0;
  logic [SW-1:0] challenge_b = '0;
  wire  [N-1:0]  ro_out;
  logic [N-1:0]  ro_enable;
  logic          busy;
  logic          done;
  logic          response;
  logic          tie;
  logic [CW-1:0] count_a;
  logic [CW-1:0] count_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  ro_puf_response_gen #(
    .NUM_RO        (N),
    .SEL_W         (SW),
    .CNT_W         (CW),
    .WINDOW_CYCLES (W),
    .SETTLE_CYCLES (S),
    .DRAIN_CYCLES  (D)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .challenge_a (challenge_a),
    .challenge_b (challenge_b),
    .ro_out      (ro_out),
    .ro_enable   (ro_enable),
    .busy        (busy),
    .done        (done),
    .response    (response),
    .tie         (tie),
    .count_a     (count_a),
    .count_b     (count_b)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Ring oscillators: toggle only while enabled, phase offset from clk edges
  for (genvar gi = 0; gi < N; gi++) begin : g_ro
    logic r;
    initial begin
      r = 1'b0;
      forever begin
        wait (ro_enable[gi] === 1'b1);
        #3;
        while (ro_enable[gi] === 1'b1) begin
          #(HALF[gi]);
          if (ro_enable[gi] === 1'b1) r = ~r;
        end
        r = 1'b0;
      end
    end
    assign ro_out[gi] = r;
  end

  // ---------------- behavioural model ----------------
  time           win_lo = 0;
  time           win_hi = 0;
  int            rises [N];
  int            base  [N];
  logic [N-1:0]  ro_prev = '0;
  bit            in_run = 1'b0;
  int            el = 0;
  logic [SW-1:0] m_a = '0;
  logic [SW-1:0] m_b = '0;

  // Rising edges of each RO that fall inside the nominal counting window
  initial begin
    for (int i = 0; i < N; i++) rises[i] = 0;
    forever begin
      @(ro_out);
      for (int i = 0; i < N; i++) begin
        if (ro_out[i] && !ro_prev[i] && ($time >= win_lo) && ($time < win_hi))
          rises[i] = rises[i] + 1;
      end
      ro_prev = ro_out;
    end
  end

  // Run tracking: acceptance only when idle, elapsed cycles since acceptance
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_run <= 1'b0;
      el     <= 0;
    end else if (start && (!in_run || el >= DL + 1)) begin
      in_run <= 1'b1;
      el     <= 0;
      m_a    <= challenge_a;
      m_b    <= challenge_b;
      win_lo <= $time + S * T;
      win_hi <= $time + (S + W) * T;
      for (int i = 0; i < N; i++) base[i] <= rises[i];
    end else if (in_run && el < DL + 5) begin
      el <= el + 1;
    end
  end

  function automatic int m_count(input logic [SW-1:0] idx);
    if (int'(idx) >= N) return 0;
    return rises[int'(idx)] - base[int'(idx)];
  endfunction

  function automatic int sat(input int x);
    return (x > SAT) ? SAT : x;
  endfunction

  function automatic logic [N-1:0] dec(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic [N-1:0] d;
    d = '0;
    if (int'(a) < N) d[int'(a)] = 1'b1;
    if (int'(b) < N) d[int'(b)] = 1'b1;
    return d;
  endfunction

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    n_cmp = n_cmp + 1;
    if (!ok) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_cnt(input string name, input logic [CW-1:0] act,
                         input logic [SW-1:0] idx, input int m);
    bit ok;
    if (int'(idx) >= N)  ok = (act == 0);
    else if (m > SAT)    ok = (act == SAT);
    else                 ok = (int'(act) >= m - 1) && (int'(act) <= m + 1);
    chk(name, ok, act, sat(m));
  endtask

  // Per-cycle comparison of every output against the model
  task automatic compare_cycle();
    int ea;
    int eb;
    bit e_tie;
    bit e_resp;
    logic [N-1:0] e_en;
    if (!rst_n || !in_run) begin
      chk("idle_busy", busy === 1'b0, busy, 0);
      chk("idle_done", done === 1'b0, done, 0);
      chk("idle_ro_enable", ro_enable === '0, ro_enable, 0);
      chk("idle_count_a", count_a === '0, count_a, 0);
      chk("idle_count_b", count_b === '0, count_b, 0);
      chk("idle_response", response === 1'b0, response, 0);
      chk("idle_tie", tie === 1'b0, tie, 0);
    end else begin
      e_en = (el < S + W) ? dec(m_a, m_b) : '0;
      chk("busy", busy === (el < DL), busy, (el < DL));
      chk("done", done === (el == DL), done, (el == DL));
      chk("ro_enable", ro_enable === e_en, ro_enable, e_en);
      if (el < DL) begin
        chk("run_count_a", count_a === '0, count_a, 0);
        chk("run_count_b", count_b === '0, count_b, 0);
        chk("run_response", response === 1'b0, response, 0);
        chk("run_tie", tie === 1'b0, tie, 0);
      end else begin
        ea     = m_count(m_a);
        eb     = m_count(m_b);
        e_tie  = (m_a == m_b) || ((int'(m_a) >= N) && (int'(m_b) >= N));
        e_resp = !e_tie && (sat(ea) > sat(eb));
        chk_cnt("res_count_a", count_a, m_a, ea);
        chk_cnt("res_count_b", count_b, m_b, eb);
        chk("res_response", response === e_resp, response, e_resp);
        chk("res_tie", tie === e_tie, tie, e_tie);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
  endtask

  // One challenge run: returns start-to-done latency and a SETTLE snapshot
  // of ro_enable; optionally re-pulses start mid-run or on the done cycle.
  task automatic do_run(input logic [SW-1:0] a, input logic [SW-1:0] b,
                        input int poke_at, input bit poke_done,
                        output int lat, output logic [N-1:0] en_snap);
    int st;
    lat     = -1;
    en_snap = '0;
    challenge_a = a;
    challenge_b = b;
    start = 1'b1;
    st = cyc;
    tick();
    start = 1'b0;
    for (int k = 1; k <= LAT + 20; k++) begin
      if (k == 3) en_snap = ro_enable;
      if (done === 1'b1) begin
        lat = cyc - st;
        break;
      end
      if (poke_at != 0 && k == poke_at) begin
        challenge_a = 4'd1;
        challenge_b = 4'd2;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    if (lat < 0) chk("done_timeout", 1'b0, LAT + 20, LAT);
    $display("run a=%0d b=%0d: latency=%0d count_a=%0d count_b=%0d response=%0b tie=%0b",
             a, b, lat, count_a, count_b, response, tie);
    if (poke_done && lat >= 0) begin
      challenge_a = 4'd5;
      challenge_b = 4'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_in_done_ignored", busy === 1'b0, busy, 0);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int lat;
    logic [N-1:0] en_snap;

    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_ro_enable", ro_enable === '0, ro_enable, 0);
    chk("reset_busy", busy === 1'b0, busy, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // (3,7): RO3 period 10, RO7 period 12 -> ~120 vs ~100
    do_run(4'd3, 4'd7, 0, 1'b0, lat, en_snap);
    chk("t1_latency", lat == LAT, lat, LAT);
    chk("t1_enable", en_snap === 12'h088, en_snap, 12'h088);
    chk("t1_count_a", count_a >= 119 && count_a <= 121, count_a, 120);
    chk("t1_count_b", count_b >= 99 && count_b <= 101, count_b, 100);
    chk("t1_response", response === 1'b1, response, 1);
    chk("t1_tie", tie === 1'b0, tie, 0);
    repeat (3) tick();

    // (5,5): same RO on both channels
    do_run(4'd5, 4'd5, 0, 1'b0, lat, en_snap);
    chk("t2_enable", en_snap === 12'h020, en_snap, 12'h020);
    chk("t2_count_a", count_a >= 84 && count_a <= 86, count_a, 85);
    chk("t2_equal", count_b == count_a, count_b, count_a);
    chk("t2_tie", tie === 1'b1, tie, 1);
    chk("t2_response", response === 1'b0, response, 0);
    repeat (3) tick();

    // (1,3): RO1 period 4 saturates an 8-bit counter
    do_run(4'd1, 4'd3, 0, 1'b0, lat, en_snap);
    chk("t3_saturate", count_a == 8'd255, count_a, 255);
    chk("t3_count_b", count_b >= 119 && count_b <= 121, count_b, 120);
    chk("t3_response", response === 1'b1, response, 1);
    repeat (3) tick();

    // (3,7) with a second start (1,2) pulsed while busy
    do_run(4'd3, 4'd7, 100, 1'b0, lat, en_snap);
    chk("t4_latency", lat == LAT, lat, LAT);
    chk("t4_count_a", count_a >= 119 && count_a <= 121, count_a, 120);
    chk("t4_count_b", count_b >= 99 && count_b <= 101, count_b, 100);
    chk("t4_response", response === 1'b1, response, 1);
    repeat (6) tick();

    // Reset dropped halfway through COUNT
    challenge_a = 4'd3;
    challenge_b = 4'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (S + W / 2) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_ro_enable", ro_enable === '0, ro_enable, 0);
    chk("t5_async_busy", busy === 1'b0, busy, 0);
    chk("t5_async_count_a", count_a === '0, count_a, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // (3,15): index beyond the array never toggles; start on done is ignored
    do_run(4'd3, 4'd15, 0, 1'b1, lat, en_snap);
    chk("t6_latency", lat == LAT, lat, LAT);
    chk("t6_enable", en_snap === 12'h008, en_snap, 12'h008);
    chk("t6_count_b", count_b == 8'd0, count_b, 0);
    chk("t6_count_a", count_a >= 119 && count_a <= 121, count_a, 120);
    chk("t6_response", response === 1'b1, response, 1);
    chk("t6_tie", tie === 1'b0, tie, 0);
    repeat (3) tick();

    // (7,3): slower RO on channel A gives response 0
    do_run(4'd7, 4'd3, 0, 1'b0, lat, en_snap);
    chk("t7_count_a", count_a >= 99 && count_a <= 101, count_a, 100);
    chk("t7_response", response === 1'b0, response, 0);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
